// File: rtl/ram_pair_burst_pkg.sv
// Shared defaults and FSM encodings for the paired-word burst RAM.
package ram_pair_burst_pkg;

  localparam int DW_DEF = 10;
  localparam int AW_DEF = 10;
  localparam int LW_DEF = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RBURST = 2'd1;
  localparam logic [1:0] ST_WBURST = 2'd2;

endpackage

// File: rtl/ram_pair_burst_bank.sv
// One word-wide bank: sync write, sync read into a reset-able output register.
// Output register only updates on a read, so it holds the last read word otherwise.
module ram_pair_burst_bank #(
  parameter int DW = 10,
  parameter int RW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [RW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**RW];
  logic [DW-1:0] rdata_q;

  // Array is deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (en_i && we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                rdata_q <= '0;
    else if (en_i && !we_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_pair_burst.sv
// Burst RAM with 2-word access at any word address; read data 1 cycle after issue, one pair/cycle.
// Reads have no backpressure; write beats stall on wr_valid=0; commands accepted only in IDLE.
module ram_pair_burst
  import ram_pair_burst_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LW-1:0]   cmd_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [2*DW-1:0] wr_data,
  input  logic [1:0]      wr_mask,
  output logic            rd_valid,
  output logic [2*DW-1:0] rd_data,
  output logic            rd_last,
  output logic            busy
);

  localparam int RW = AW - 1;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          rd_valid_q, rd_last_q, swap_q;

  logic          accept, issue_rd, issue_wr, step;
  logic [RW-1:0] row_lo, row_hi;
  logic          en0, en1;
  logic [RW-1:0] addr0;
  logic [DW-1:0] wdat0, wdat1, dout0, dout1;

  assign cmd_ready = (state_q == ST_IDLE);
  assign wr_ready  = (state_q == ST_WBURST);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign issue_rd  = (state_q == ST_RBURST);
  assign issue_wr  = (state_q == ST_WBURST) && wr_valid;
  assign step      = issue_rd || issue_wr;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = cmd_we ? ST_WBURST : ST_RBURST;
      ptr_d   = cmd_addr;
      cnt_d   = cmd_len;
    end else if (step) begin
      ptr_d = ptr_q + AW'(2);
      cnt_d = cnt_q - LW'(1);
      if (cnt_q == '0) state_d = ST_IDLE;
    end
  end

  // Odd pointer: lo word sits in the odd bank at row r, hi word in the even bank at row r+1.
  assign row_lo = ptr_q[AW-1:1];
  assign row_hi = row_lo + RW'(1);
  assign addr0  = ptr_q[0] ? row_hi : row_lo;
  assign en0    = issue_rd || (issue_wr && (ptr_q[0] ? wr_mask[1] : wr_mask[0]));
  assign en1    = issue_rd || (issue_wr && (ptr_q[0] ? wr_mask[0] : wr_mask[1]));
  assign wdat0  = ptr_q[0] ? wr_data[2*DW-1:DW] : wr_data[DW-1:0];
  assign wdat1  = ptr_q[0] ? wr_data[DW-1:0]    : wr_data[2*DW-1:DW];

  ram_pair_burst_bank #(.DW(DW), .RW(RW)) u_bank_even (
    .clk(clk), .rst(rst), .en_i(en0), .we_i(issue_wr),
    .addr_i(addr0), .wdata_i(wdat0), .rdata_o(dout0)
  );

  ram_pair_burst_bank #(.DW(DW), .RW(RW)) u_bank_odd (
    .clk(clk), .rst(rst), .en_i(en1), .we_i(issue_wr),
    .addr_i(row_lo), .wdata_i(wdat1), .rdata_o(dout1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      swap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= issue_rd;
      rd_last_q  <= issue_rd && (cnt_q == '0);
      if (issue_rd) swap_q <= ptr_q[0];
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign rd_data  = swap_q ? {dout0, dout1} : {dout1, dout0};

endmodule

// File: tb/tb_ram_pair_burst.sv
// Randomized scoreboard bench for ram_pair_burst against a flat word-array reference model.
module tb_ram_pair_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [9:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [19:0] wr_data;
  logic [1:0]  wr_mask;
  logic        rd_valid, rd_last, busy;
  logic [19:0] rd_data;

  int vectors = 0;
  int miscompares = 0;

  logic [9:0]  mem [1024];
  logic [19:0] beat_dat [16];
  logic [1:0]  beat_msk [16];

  typedef struct packed {
    logic [19:0] dat;
    logic        last;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ram_pair_burst dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .busy(busy)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] pair_at(input int p);
    return {mem[(p + 1) % 1024], mem[p % 1024]};
  endfunction

  // Monitor: every presented read beat must be the next expected pair.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rd_beat", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rd_data", rd_data, e.dat);
          check("rd_last", rd_last, e.last);
        end
      end else begin
        check("rd_last_idle", rd_last, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic we, input int addr, input int len);
    for (int k = 0; k < 200 && !cmd_ready; k++) tick();
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = 10'(addr);
    cmd_len   = 4'(len);
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 10'($urandom);
  endtask

  task automatic write_beat(input int p, input logic [19:0] d, input logic [1:0] m);
    if ($urandom_range(0, 3) == 0) tick();
    check("wr_ready", wr_ready, 1);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_mask  = m;
    tick();
    wr_valid = 1'b0;
    wr_data  = 20'($urandom);
    if (m[0]) mem[p % 1024] = d[9:0];
    if (m[1]) mem[(p + 1) % 1024] = d[19:10];
  endtask

  task automatic write_burst(input int addr, input int len);
    do_cmd(1'b1, addr, len);
    for (int i = 0; i <= len; i++) write_beat(addr + 2 * i, beat_dat[i], beat_msk[i]);
  endtask

  task automatic read_burst(input int addr, input int len);
    exp_t e;
    do_cmd(1'b0, addr, len);
    for (int i = 0; i <= len; i++) begin
      e.dat  = pair_at(addr + 2 * i);
      e.last = (i == len);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) tick();
    check("sb_drain", sb.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_wr_ready"}, wr_ready, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; wr_mask = '0;
    #12;
    check_idle_outputs("reset");
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_last", rd_last, 0);
    tick();
    rst = 1'b0;
    tick();

    // Fill the whole array so every later read has a defined model value.
    for (int b = 0; b < 32; b++) begin
      for (int i = 0; i < 16; i++) begin
        beat_dat[i] = 20'($urandom);
        beat_msk[i] = 2'b11;
      end
      write_burst(b * 32, 15);
    end
    read_burst(500, 3);
    drain();

    rst = 1'b1;
    tick();
    check_idle_outputs("idle_rst");
    check("idle_rst_rd_data", rd_data, 0);
    rst = 1'b0;
    tick();

    // Aligned single pair, with issue-to-valid timing.
    beat_dat[0] = {10'd3, 10'd5}; beat_msk[0] = 2'b11;
    write_burst(10, 0);
    read_burst(10, 0);
    check("lat_rd_valid_accept", rd_valid, 0);
    tick();
    check("lat_rd_valid_next", rd_valid, 1);
    check("lat_rd_last", rd_last, 1);
    check("lat_rd_data", rd_data, {10'd3, 10'd5});
    drain();

    // Lo-only write, then misaligned read across it.
    beat_dat[0] = {10'd999, 10'd0}; beat_msk[0] = 2'b01;
    write_burst(12, 0);
    read_burst(11, 0);
    drain();
    check("model_odd_pair", pair_at(11), {10'd0, 10'd3});

    // Wrap-around pair at the top of the array.
    beat_dat[0] = {10'd7, 10'd9}; beat_msk[0] = 2'b11;
    write_burst(1023, 0);
    check("model_wrap_ram0", mem[0], 10'd7);
    read_burst(1023, 0);
    drain();

    // Three back-to-back beats; rd_last only on the third.
    for (int i = 0; i < 3; i++) begin
      beat_dat[i] = {10'(2 * i + 2), 10'(2 * i + 1)};
      beat_msk[i] = 2'b11;
    end
    write_burst(50, 2);
    read_burst(50, 2);
    drain();

    beat_dat[0] = {10'd1, 10'd2}; beat_msk[0] = 2'b01;
    write_burst(60, 0);
    read_burst(60, 0);
    drain();

    // Reset after the first write beat: only that beat lands.
    do_cmd(1'b1, 200, 3);
    write_beat(200, {10'd111, 10'd222}, 2'b11);
    rst = 1'b1;
    #2;
    check_idle_outputs("wr_midrst");
    tick();
    rst = 1'b0;
    tick();
    read_burst(200, 3);
    drain();

    // Reset during a read burst drops outstanding beats.
    read_burst(300, 7);
    tick();
    tick();
    rst = 1'b1;
    #2;
    sb.delete();
    check_idle_outputs("rd_midrst");
    tick();
    rst = 1'b0;
    tick();

    for (int n = 0; n < 40; n++) begin
      int a, l;
      a = $urandom_range(0, 1023);
      l = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          beat_dat[i] = 20'($urandom);
          beat_msk[i] = 2'($urandom);
        end
        write_burst(a, l);
      end else begin
        read_burst(a, l);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
